// File: rtl/locker_pkg.sv
// Shared definitions for the digital locker: FSM state encoding, code width
// and default timing constants.
package locker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StLocked   = 2'd0;
  localparam state_t StUnlocked = 2'd1;
  localparam state_t StSetEntry = 2'd2;
  localparam state_t StLockout  = 2'd3;

  localparam int unsigned DefaultDigits        = 4;
  localparam int unsigned CODE_W               = 4 * DefaultDigits;
  localparam int unsigned DefaultMaxAttempts   = 3;
  localparam int unsigned DefaultLockoutCycles = 16;
  localparam int unsigned DefaultUnlockCycles  = 8;

  // Width of a down-counter able to hold the larger of two cycle counts.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/keypad_shift_buffer.sv
// Collects keypad digits MSB-first into a code word; clear wins over a
// simultaneous digit, and digits beyond a full entry are dropped.
module keypad_shift_buffer #(
  parameter int unsigned Digits = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  digit_valid_i,
  input  logic [3:0]            digit_i,
  output logic [4*Digits-1:0]   code_o,
  output logic [2:0]            count_o,
  output logic                  full_o
);

  logic [4*Digits-1:0] code_q, code_d;
  logic [2:0]          count_q, count_d;

  assign full_o  = (count_q == 3'(Digits));
  assign code_o  = code_q;
  assign count_o = count_q;

  always_comb begin
    code_d  = code_q;
    count_d = count_q;
    if (clear_i) begin
      code_d  = '0;
      count_d = '0;
    end else if (digit_valid_i && !full_o) begin
      code_d      = code_q << 4;
      code_d[3:0] = digit_i;
      count_d     = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      count_q <= '0;
    end else begin
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/locker_controller.sv
// Locker sequencer: checks or programs the keypad code, counts failed attempts,
// and times the unlock window and the lockout period.
module locker_controller import locker_pkg::*; #(
  parameter int unsigned        DIGITS         = DefaultDigits,
  parameter int unsigned        MAX_ATTEMPTS   = DefaultMaxAttempts,
  parameter int unsigned        LOCKOUT_CYCLES = DefaultLockoutCycles,
  parameter int unsigned        UNLOCK_CYCLES  = DefaultUnlockCycles,
  parameter logic [4*DIGITS-1:0] DEFAULT_PW    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            A,
  input  logic                  DigitValid,
  input  logic                  SetPasswordButton,
  input  logic                  EnterButton,
  input  logic                  ClearButton,
  output logic [4*DIGITS-1:0]   StoredPassword,
  output logic                  Unlocked,
  output logic                  Alarm,
  output logic                  SetMode,
  output logic [2:0]            DigitCount,
  output logic                  Error
);

  localparam int unsigned TimerW = timer_width(LOCKOUT_CYCLES, UNLOCK_CYCLES);

  state_t              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [2:0]          attempts_q, attempts_d;
  logic [4*DIGITS-1:0] pw_q, pw_d;
  logic                error_q, error_d;

  logic [4*DIGITS-1:0] code;
  logic                full;
  logic                enter;
  logic                in_lockout;

  assign in_lockout = (state_q == StLockout);
  assign enter      = EnterButton && !ClearButton;

  // Every Enter consumes the entry, and the buffer is pinned at zero in lockout.
  keypad_shift_buffer #(
    .Digits (DIGITS)
  ) u_buffer (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (ClearButton || EnterButton || in_lockout),
    .digit_valid_i (DigitValid && !in_lockout),
    .digit_i       (A),
    .code_o        (code),
    .count_o       (DigitCount),
    .full_o        (full)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    attempts_d = attempts_q;
    pw_d       = pw_q;
    error_d    = 1'b0;
    case (state_q)
      StLocked: begin
        if (enter) begin
          if (!full) begin
            error_d = 1'b1;
          end else if (code == pw_q) begin
            state_d    = StUnlocked;
            timer_d    = TimerW'(UNLOCK_CYCLES);
            attempts_d = '0;
          end else begin
            error_d    = 1'b1;
            attempts_d = attempts_q + 3'd1;
            if (attempts_d == 3'(MAX_ATTEMPTS)) begin
              state_d = StLockout;
              timer_d = TimerW'(LOCKOUT_CYCLES);
            end
          end
        end
      end
      StUnlocked: begin
        if (SetPasswordButton) begin
          state_d = StSetEntry;
        end else if (timer_q <= TimerW'(1)) begin
          state_d = StLocked;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StSetEntry: begin
        if (!SetPasswordButton) begin
          state_d = StLocked;
          timer_d = '0;
        end else if (enter) begin
          if (full) begin
            pw_d    = code;
            state_d = StLocked;
            timer_d = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: begin
        if (timer_q <= TimerW'(1)) begin
          state_d    = StLocked;
          timer_d    = '0;
          attempts_d = '0;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLocked;
      timer_q    <= '0;
      attempts_q <= '0;
      pw_q       <= DEFAULT_PW;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      attempts_q <= attempts_d;
      pw_q       <= pw_d;
      error_q    <= error_d;
    end
  end

  assign StoredPassword = pw_q;
  assign Unlocked       = (state_q == StUnlocked) || (state_q == StSetEntry);
  assign SetMode        = (state_q == StSetEntry);
  assign Alarm          = in_lockout;
  assign Error          = error_q;

endmodule

// File: tb/tb_locker_controller.sv
// Directed bench for locker_controller: unlock window, password change,
// lockout, short/cleared entries and asynchronous reset.
module tb_locker_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  A;
  logic        DigitValid;
  logic        SetPasswordButton;
  logic        EnterButton;
  logic        ClearButton;
  logic [15:0] StoredPassword;
  logic        Unlocked;
  logic        Alarm;
  logic        SetMode;
  logic [2:0]  DigitCount;
  logic        Error;

  int errors = 0;
  int checks = 0;

  locker_controller dut (
    .clk               (clk),
    .rst               (rst),
    .A                 (A),
    .DigitValid        (DigitValid),
    .SetPasswordButton (SetPasswordButton),
    .EnterButton       (EnterButton),
    .ClearButton       (ClearButton),
    .StoredPassword    (StoredPassword),
    .Unlocked          (Unlocked),
    .Alarm             (Alarm),
    .SetMode           (SetMode),
    .DigitCount        (DigitCount),
    .Error             (Error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press_digit(input logic [3:0] d);
    A = d;
    DigitValid = 1'b1;
    tick();
    DigitValid = 1'b0;
  endtask

  task automatic press_code(input logic [15:0] c);
    press_digit(c[15:12]);
    press_digit(c[11:8]);
    press_digit(c[7:4]);
    press_digit(c[3:0]);
  endtask

  task automatic press_enter();
    EnterButton = 1'b1;
    tick();
    EnterButton = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++;
    if ({Unlocked, Alarm, SetMode, Error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: {U,A,S,E}=%b expected 0000", {Unlocked, Alarm, SetMode, Error});
    end
    checks++;
    if (StoredPassword !== 16'h0000) begin
      errors++;
      $display("FAIL reset_pw: StoredPassword=%h expected 0000", StoredPassword);
    end
    checks++;
    if (DigitCount !== 3'd0) begin
      errors++;
      $display("FAIL reset_count: DigitCount=%0d expected 0", DigitCount);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_unlock_timeout();
    int cnt;
    press_code(16'h0000);
    checks++;
    if (DigitCount !== 3'd4) begin
      errors++;
      $display("FAIL full_count: DigitCount=%0d expected 4", DigitCount);
    end
    press_enter();
    checks++;
    if ({Unlocked, Error, DigitCount} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL unlock_rise: U=%b E=%b cnt=%0d expected U=1 E=0 cnt=0",
               Unlocked, Error, DigitCount);
    end
    cnt = 1;
    while (Unlocked === 1'b1 && cnt < 40) begin
      idle(1);
      if (Unlocked === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL unlock_window: open for %0d cycles expected 8", cnt);
    end
  endtask

  task automatic test_short_entry();
    press_code(16'h9999);
    press_enter();
    checks++;
    if (Error !== 1'b1) begin
      errors++;
      $display("FAIL wrong_code_error: Error=%b expected 1", Error);
    end
    idle(1);
    checks++;
    if (Error !== 1'b0) begin
      errors++;
      $display("FAIL error_pulse_width: Error=%b expected 0", Error);
    end
    press_digit(4'd1);
    press_digit(4'd2);
    checks++;
    if (DigitCount !== 3'd2) begin
      errors++;
      $display("FAIL partial_count: DigitCount=%0d expected 2", DigitCount);
    end
    press_enter();
    checks++;
    if ({Error, DigitCount} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL short_entry: E=%b cnt=%0d expected E=1 cnt=0", Error, DigitCount);
    end
    // Second wrong code: only two counted attempts, so no lockout yet.
    press_code(16'h9999);
    press_enter();
    checks++;
    if ({Error, Alarm} !== 2'b10) begin
      errors++;
      $display("FAIL short_not_counted: E=%b Alarm=%b expected E=1 Alarm=0", Error, Alarm);
    end
    press_code(16'h0000);
    press_enter();
    checks++;
    if (Unlocked !== 1'b1) begin
      errors++;
      $display("FAIL unlock_after_fail: Unlocked=%b expected 1", Unlocked);
    end
    idle(8);
    checks++;
    if (Unlocked !== 1'b0) begin
      errors++;
      $display("FAIL relock: Unlocked=%b expected 0", Unlocked);
    end
  endtask

  task automatic test_clear();
    press_digit(4'd5);
    press_digit(4'd6);
    press_digit(4'd7);
    checks++;
    if (DigitCount !== 3'd3) begin
      errors++;
      $display("FAIL clear_pre_count: DigitCount=%0d expected 3", DigitCount);
    end
    A = 4'd8;
    DigitValid = 1'b1;
    ClearButton = 1'b1;
    tick();
    DigitValid = 1'b0;
    ClearButton = 1'b0;
    checks++;
    if (DigitCount !== 3'd0) begin
      errors++;
      $display("FAIL clear_priority: DigitCount=%0d expected 0", DigitCount);
    end
    press_code(16'h0000);
    press_enter();
    checks++;
    if (Unlocked !== 1'b1) begin
      errors++;
      $display("FAIL clear_then_unlock: Unlocked=%b expected 1", Unlocked);
    end
    idle(8);
  endtask

  task automatic test_set_password();
    press_code(16'h0000);
    press_enter();
    SetPasswordButton = 1'b1;
    idle(1);
    checks++;
    if ({SetMode, Unlocked} !== 2'b11) begin
      errors++;
      $display("FAIL set_mode_entry: SetMode=%b U=%b expected 1 1", SetMode, Unlocked);
    end
    press_code(16'h1234);
    // Unlock timer is frozen, so the lock is still open after 6 cycles here.
    checks++;
    if (Unlocked !== 1'b1) begin
      errors++;
      $display("FAIL timer_frozen: Unlocked=%b expected 1", Unlocked);
    end
    press_enter();
    checks++;
    if ({StoredPassword, SetMode, Unlocked} !== {16'h1234, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL set_password: pw=%h S=%b U=%b expected pw=1234 S=0 U=0",
               StoredPassword, SetMode, Unlocked);
    end
    SetPasswordButton = 1'b0;
    idle(1);
    press_code(16'h0000);
    press_enter();
    checks++;
    if ({Unlocked, Error} !== 2'b01) begin
      errors++;
      $display("FAIL old_pw_rejected: U=%b E=%b expected U=0 E=1", Unlocked, Error);
    end
    press_code(16'h1234);
    press_enter();
    checks++;
    if (Unlocked !== 1'b1) begin
      errors++;
      $display("FAIL new_pw_unlock: Unlocked=%b expected 1", Unlocked);
    end
    idle(8);
  endtask

  task automatic test_simultaneous();
    press_digit(4'd1);
    press_digit(4'd2);
    press_digit(4'd3);
    A = 4'd4;
    DigitValid = 1'b1;
    EnterButton = 1'b1;
    tick();
    DigitValid = 1'b0;
    EnterButton = 1'b0;
    checks++;
    if ({Unlocked, Error, DigitCount} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL digit_with_enter: U=%b E=%b cnt=%0d expected U=0 E=1 cnt=0",
               Unlocked, Error, DigitCount);
    end
    press_code(16'h1234);
    press_digit(4'd5);
    checks++;
    if (DigitCount !== 3'd4) begin
      errors++;
      $display("FAIL overflow_count: DigitCount=%0d expected 4", DigitCount);
    end
    press_enter();
    checks++;
    if (Unlocked !== 1'b1) begin
      errors++;
      $display("FAIL overflow_ignored: Unlocked=%b expected 1", Unlocked);
    end
    idle(8);
    press_code(16'h9999);
    EnterButton = 1'b1;
    ClearButton = 1'b1;
    tick();
    EnterButton = 1'b0;
    ClearButton = 1'b0;
    checks++;
    if ({Error, DigitCount} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL enter_with_clear: E=%b cnt=%0d expected E=0 cnt=0", Error, DigitCount);
    end
  endtask

  task automatic test_lockout();
    int cnt;
    for (int i = 0; i < 3; i++) begin
      press_code(16'h9999);
      press_enter();
      checks++;
      if ({Error, Alarm} !== {1'b1, (i == 2)}) begin
        errors++;
        $display("FAIL attempt_%0d: E=%b Alarm=%b expected E=1 Alarm=%b",
                 i, Error, Alarm, (i == 2));
      end
    end
    press_code(16'h1234);
    press_enter();
    checks++;
    if ({Unlocked, Alarm, Error, DigitCount} !== {1'b0, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL lockout_ignores: U=%b Alarm=%b E=%b cnt=%0d expected 0 1 0 0",
               Unlocked, Alarm, Error, DigitCount);
    end
    cnt = 6;
    while (Alarm === 1'b1 && cnt < 60) begin
      idle(1);
      if (Alarm === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 16) begin
      errors++;
      $display("FAIL lockout_length: Alarm high %0d cycles expected 16", cnt);
    end
    press_code(16'h1234);
    press_enter();
    checks++;
    if (Unlocked !== 1'b1) begin
      errors++;
      $display("FAIL unlock_after_lockout: Unlocked=%b expected 1", Unlocked);
    end
    idle(8);
  endtask

  task automatic test_reset_mid();
    press_code(16'h1234);
    press_enter();
    SetPasswordButton = 1'b1;
    idle(1);
    press_digit(4'd1);
    press_digit(4'd2);
    checks++;
    if ({SetMode, DigitCount} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL mid_set_entry: S=%b cnt=%0d expected S=1 cnt=2", SetMode, DigitCount);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({Unlocked, Alarm, SetMode, Error, DigitCount, StoredPassword} !== '0) begin
      errors++;
      $display("FAIL async_reset: U=%b A=%b S=%b E=%b cnt=%0d pw=%h expected all 0",
               Unlocked, Alarm, SetMode, Error, DigitCount, StoredPassword);
    end
    SetPasswordButton = 1'b0;
    tick();
    rst = 1'b0;
    idle(1);
    press_code(16'h0000);
    press_enter();
    checks++;
    if (Unlocked !== 1'b1) begin
      errors++;
      $display("FAIL default_pw_restored: Unlocked=%b expected 1", Unlocked);
    end
  endtask

  initial begin
    rst = 1'b1;
    A = 4'd0;
    DigitValid = 1'b0;
    SetPasswordButton = 1'b0;
    EnterButton = 1'b0;
    ClearButton = 1'b0;
    test_reset();
    test_unlock_timeout();
    test_short_entry();
    test_clear();
    test_set_password();
    test_simultaneous();
    test_lockout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
